// File: rtl/fifo_ctrl.sv
// fifo_ctrl: handshake and pointer controller for a FIFO whose storage (register file plus
// wr_ptr/rd_ptr/num_item registers) lives outside this block. Each cycle the controller reads
// the current storage state and returns the next state. The head item is staged in an output
// register, so total capacity is DEPTH + 1.
//
// Ports
//   clk, rst         clock; synchronous active-high reset
//   in_valid/in_data/in_ready      write-side handshake
//   out_valid/out_data/out_ready   read-side handshake (out_data is registered)
//   flush            discard all contents
//   wr_ptr, rd_ptr, num_item, dout current storage state and read data at rd_ptr
//   reg_push, din    storage write strobe and data (written at wr_ptr)
//   next_wrptr, next_rdptr, next_numitem  next storage state
//   occupancy        num_item + out_valid
//   almost_full      occupancy >= AFULL_TH
//   max_occ          high-water mark of occupancy since the last reset/flush
module fifo_ctrl #(
  parameter int unsigned ADDR_BW  = 1,
  parameter int unsigned DATA_BW  = 4,
  parameter int unsigned AFULL_TH = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [DATA_BW-1:0] in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [DATA_BW-1:0] out_data,
  input  logic               out_ready,
  input  logic               flush,
  input  logic [ADDR_BW-1:0] wr_ptr,
  input  logic [ADDR_BW-1:0] rd_ptr,
  input  logic [ADDR_BW:0]   num_item,
  input  logic [DATA_BW-1:0] dout,
  output logic               reg_push,
  output logic [DATA_BW-1:0] din,
  output logic [ADDR_BW-1:0] next_wrptr,
  output logic [ADDR_BW-1:0] next_rdptr,
  output logic [ADDR_BW:0]   next_numitem,
  output logic [ADDR_BW+1:0] occupancy,
  output logic               almost_full,
  output logic [ADDR_BW+1:0] max_occ
);

  localparam int unsigned DEPTH = 2 ** ADDR_BW;
  localparam logic [ADDR_BW:0]   DepthCnt = DEPTH[ADDR_BW:0];
  localparam logic [ADDR_BW+1:0] AfullTh  = AFULL_TH[ADDR_BW+1:0];

  typedef enum logic [0:0] {
    StRun,
    StFlush
  } state_e;

  state_e r_state_q, w_state_d;

  logic               r_out_valid_q, w_out_valid_d;
  logic [DATA_BW-1:0] r_out_data_q, w_out_data_d;
  logic [ADDR_BW+1:0] r_max_occ_q, w_max_occ_d;

  logic               w_run;
  logic               w_in_ready;
  logic               w_push;
  logic               w_pop;
  logic [ADDR_BW+1:0] w_occupancy;

  // ---------------------------------------------------------------------------
  // FSM: a flush always lands in StFlush; StFlush lasts one cycle unless flush is held.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= StRun;
    end else begin
      r_state_q <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state_q;
    case (r_state_q)
      StRun:   if (flush)  w_state_d = StFlush;
      StFlush: if (!flush) w_state_d = StRun;
      default: w_state_d = StRun;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_run      = (r_state_q == StRun);
    w_in_ready = w_run && !flush && (num_item < DepthCnt);
    w_push     = in_valid && w_in_ready;
    // Refill the output register whenever it is empty or being drained this cycle.
    w_pop      = (num_item != '0) && (!r_out_valid_q || out_ready) && w_run && !flush;
    w_occupancy = {1'b0, num_item} + (ADDR_BW + 2)'(r_out_valid_q);
  end

  // ---------------------------------------------------------------------------
  // Next storage state. In StFlush push/pop are both zero, so pointers hold.
  // ---------------------------------------------------------------------------
  always_comb begin
    reg_push     = w_push;
    din          = in_data;
    next_wrptr   = wr_ptr + ADDR_BW'(w_push);
    next_rdptr   = rd_ptr + ADDR_BW'(w_pop);
    next_numitem = num_item + (ADDR_BW + 1)'(w_push) - (ADDR_BW + 1)'(w_pop);
    if (rst || flush) begin
      reg_push     = 1'b0;
      next_wrptr   = '0;
      next_rdptr   = '0;
      next_numitem = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register and high-water mark
  // ---------------------------------------------------------------------------
  always_comb begin
    w_out_valid_d = r_out_valid_q;
    w_out_data_d  = r_out_data_q;
    w_max_occ_d   = r_max_occ_q;
    if (flush) begin
      w_out_valid_d = 1'b0;
      w_max_occ_d   = '0;
    end else begin
      if (w_pop) begin
        w_out_valid_d = 1'b1;
        w_out_data_d  = dout;
      end else if (r_out_valid_q && out_ready) begin
        w_out_valid_d = 1'b0;
      end
      if (w_run && (w_occupancy > r_max_occ_q)) begin
        w_max_occ_d = w_occupancy;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid_q <= 1'b0;
      r_out_data_q  <= '0;
      r_max_occ_q   <= '0;
    end else begin
      r_out_valid_q <= w_out_valid_d;
      r_out_data_q  <= w_out_data_d;
      r_max_occ_q   <= w_max_occ_d;
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = r_out_valid_q;
  assign out_data    = r_out_data_q;
  assign occupancy   = w_occupancy;
  assign almost_full = (w_occupancy >= AfullTh);
  assign max_occ     = r_max_occ_q;

endmodule
